// File: rtl/expression_pipe_pkg.sv
// Shared types and helpers for the pipelined expression evaluator.
// Saturation helpers take a wide exact result and clamp it into a w-bit lane range.
package expression_pipe_pkg;

    localparam int OPW = 3;
    // Wide enough to hold any exact intermediate: a 2*16-bit shift result plus sign.
    localparam int XW  = 34;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_XNOR = 3'd3,
        OP_SHL  = 3'd4,
        OP_SHR  = 3'd5,
        OP_GE   = 3'd6,
        OP_ACC  = 3'd7
    } op_t;

    function automatic logic [15:0] sat_s(input logic signed [XW-1:0] v, input int w);
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        logic signed [XW-1:0] r;
        hi = (XW'(1) << (w - 1)) - XW'(1);
        lo = ~hi;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        return r[15:0];
    endfunction

    function automatic logic [15:0] sat_u(input logic signed [XW-1:0] v, input int w);
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] r;
        hi = (XW'(1) << w) - XW'(1);
        if (v[XW-1]) begin
            r = '0;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r[15:0];
    endfunction

endpackage

// File: rtl/expression_pipe_eval_alu.sv
// One combinational lane: evaluates the opcode on exact wide values, then wraps or saturates.
module expression_lane_alu
    import expression_pipe_pkg::*;
#(
    parameter int W   = 6,
    parameter int SAT = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  op_t          op,
    input  logic         sgn,
    input  logic [W-1:0] acc,
    output logic [W-1:0] y,
    output logic [W-1:0] acc_nxt
);

    logic signed [XW-1:0] xa;
    logic signed [XW-1:0] xb;
    logic signed [XW-1:0] xacc;
    logic signed [XW-1:0] xshl;
    logic signed [XW-1:0] res_x;
    logic [2*W-1:0]       shl_w;
    logic [W-1:0]         y_direct;
    logic                 direct;
    logic [15:0]          sat_x;

    always_comb begin
        xa   = sgn ? {{(XW-W){a[W-1]}}, a}     : {{(XW-W){1'b0}}, a};
        xb   = sgn ? {{(XW-W){b[W-1]}}, b}     : {{(XW-W){1'b0}}, b};
        xacc = sgn ? {{(XW-W){acc[W-1]}}, acc} : {{(XW-W){1'b0}}, acc};

        // The left shift is evaluated in 2W bits, so bits shifted past 2W are lost first.
        shl_w = {{W{sgn & a[W-1]}}, a} << b[2:0];
        xshl  = sgn ? {{(XW-2*W){shl_w[2*W-1]}}, shl_w} : {{(XW-2*W){1'b0}}, shl_w};

        res_x    = '0;
        y_direct = '0;
        direct   = 1'b0;
        case (op)
            OP_ADD:  res_x = xa + xb;
            OP_SUB:  res_x = xa - xb;
            OP_ACC:  res_x = xacc + xb;
            OP_SHL:  res_x = xshl;
            OP_SHR:  res_x = xa >>> b[2:0];
            OP_AND: begin
                direct   = 1'b1;
                y_direct = a & b;
            end
            OP_XNOR: begin
                direct   = 1'b1;
                y_direct = ~(a ^ b);
            end
            OP_GE: begin
                direct   = 1'b1;
                y_direct = {{(W-1){1'b0}}, (xa >= xb)};
            end
            default: res_x = '0;
        endcase

        sat_x = sgn ? sat_s(res_x, W) : sat_u(res_x, W);

        if (direct) begin
            y = y_direct;
        end else if (SAT != 0) begin
            y = sat_x[W-1:0];
        end else begin
            y = res_x[W-1:0];
        end
        acc_nxt = y;
    end

endmodule

// File: rtl/expression_pipe_eval.sv
// Two-stage valid/ready pipeline of LANES expression ALUs with per-lane accumulators.
// S1 holds the accepted operands; S2 holds the computed result until downstream takes it.
module expression_pipe_eval
    import expression_pipe_pkg::*;
#(
    parameter int W     = 6,
    parameter int LANES = 4,
    parameter int SAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    input  logic [LANES*OPW-1:0] in_op,
    input  logic [LANES-1:0]     in_sgn,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_y
);

    logic                 s1_valid_reg;
    logic [LANES*W-1:0]   s1_a_reg;
    logic [LANES*W-1:0]   s1_b_reg;
    logic [LANES*OPW-1:0] s1_op_reg;
    logic [LANES-1:0]     s1_sgn_reg;
    logic                 out_valid_reg;
    logic [LANES*W-1:0]   out_y_reg;
    logic [LANES*W-1:0]   y_next;

    logic stall;
    logic s1_load;
    logic s2_load;
    logic beat_move;

    assign stall     = out_valid_reg && !out_ready;
    assign s2_load   = !stall;
    assign s1_load   = !s1_valid_reg || !stall;
    assign beat_move = s2_load && s1_valid_reg;

    assign in_ready  = s1_load;
    assign out_valid = out_valid_reg;
    assign out_y     = out_y_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= '0;
            s1_sgn_reg   <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg   <= in_a;
                s1_b_reg   <= in_b;
                s1_op_reg  <= in_op;
                s1_sgn_reg <= in_sgn;
            end
        end
    end

    // out_y only changes when a real beat lands, so a drained pipe keeps the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
        end else if (s2_load) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_y_reg <= y_next;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
            logic [W-1:0] acc_reg;
            logic [W-1:0] acc_in;
            logic [W-1:0] acc_nxt;
            logic [W-1:0] y_lane;
            op_t          lane_op;

            assign lane_op = op_t'(s1_op_reg[gi*OPW +: OPW]);
            // A clear coinciding with an ACC beat makes that beat start from zero.
            assign acc_in  = acc_clr ? '0 : acc_reg;

            expression_lane_alu #(
                .W   (W),
                .SAT (SAT)
            ) u_alu (
                .a       (s1_a_reg[gi*W +: W]),
                .b       (s1_b_reg[gi*W +: W]),
                .op      (lane_op),
                .sgn     (s1_sgn_reg[gi]),
                .acc     (acc_in),
                .y       (y_lane),
                .acc_nxt (acc_nxt)
            );

            assign y_next[(LANES-1-gi)*W +: W] = y_lane;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (beat_move && lane_op == OP_ACC) begin
                    acc_reg <= acc_nxt;
                end else if (acc_clr) begin
                    acc_reg <= '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_expression_pipe_eval.sv
// Directed table plus hand sequences and a randomised scoreboard run, on SAT=0 and SAT=1 copies.
module tb_expression_pipe_eval;
    import expression_pipe_pkg::*;

    localparam int W      = 6;
    localparam int LANES  = 4;
    localparam int AW     = LANES * W;
    localparam int N_RAND = 10000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic             acc_clr;
    logic [AW-1:0]    in_a;
    logic [AW-1:0]    in_b;
    logic [LANES*3-1:0] in_op;
    logic [LANES-1:0] in_sgn;
    logic             in_ready0, in_ready1;
    logic             out_valid0, out_valid1;
    logic [AW-1:0]    out_y0, out_y1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    expression_pipe_eval #(.W(W), .LANES(LANES), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sgn(in_sgn), .acc_clr(acc_clr),
        .out_valid(out_valid0), .out_ready(out_ready), .out_y(out_y0)
    );

    expression_pipe_eval #(.W(W), .LANES(LANES), .SAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sgn(in_sgn), .acc_clr(acc_clr),
        .out_valid(out_valid1), .out_ready(out_ready), .out_y(out_y1)
    );

    typedef struct {
        string        name;
        int           lane;
        logic [W-1:0] a;
        logic [W-1:0] b;
        op_t          op;
        logic         sgn;
        logic [W-1:0] y_wrap;
        logic [W-1:0] y_sat;
    } vec_t;

    vec_t vecs[$];
    logic [W-1:0] macc0[LANES];
    logic [W-1:0] macc1[LANES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string n, input int lane, input int a, input int b,
                           input op_t op, input bit sgn, input int yw, input int ys);
        vec_t v;
        v.name   = n;
        v.lane   = lane;
        v.a      = W'(a);
        v.b      = W'(b);
        v.op     = op;
        v.sgn    = sgn;
        v.y_wrap = W'(yw);
        v.y_sat  = W'(ys);
        vecs.push_back(v);
    endtask

    task automatic set_lane(input int lane, input logic [W-1:0] a, input logic [W-1:0] b,
                            input op_t op, input logic sgn);
        in_a   = '0;
        in_b   = '0;
        in_op  = '0;
        in_sgn = '0;
        in_a[lane*W +: W] = a;
        in_b[lane*W +: W] = b;
        in_op[lane*3 +: 3] = op;
        in_sgn[lane]       = sgn;
    endtask

    // One beat into an idle pipe with out_ready high; result is checked two cycles after accept.
    task automatic run_single(input string name, input int lane, input logic [W-1:0] a,
                              input logic [W-1:0] b, input op_t op, input logic sgn,
                              input logic [W-1:0] yw, input logic [W-1:0] ys);
        logic [AW-1:0] e0;
        logic [AW-1:0] e1;
        e0 = '0;
        e1 = '0;
        e0[(LANES-1-lane)*W +: W] = yw;
        e1[(LANES-1-lane)*W +: W] = ys;
        set_lane(lane, a, b, op, sgn);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        check({name, " in_ready"}, {in_ready0, in_ready1}, 2'b11);
        tick();
        in_valid = 1'b0;
        tick();
        check({name, " out_valid"}, {out_valid0, out_valid1}, 2'b11);
        check({name, " y wrap"}, out_y0, e0);
        check({name, " y sat"}, out_y1, e1);
        $display("vec %-12s lane%0d op=%0d sgn=%0d a=%0d b=%0d -> wrap=%0d sat=%0d",
                 name, lane, op, sgn, a, b, out_y0[(LANES-1-lane)*W +: W],
                 out_y1[(LANES-1-lane)*W +: W]);
    endtask

    function automatic int to_int(input logic [W-1:0] v, input logic sgn);
        return (sgn && v[W-1]) ? int'(v) - (1 << W) : int'(v);
    endfunction

    function automatic logic [W-1:0] model_lane(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [2:0] op, input logic sgn,
                                                input logic [W-1:0] acc, input bit sat);
        int sa, sb, r, sh, lo, hi;
        sa = to_int(a, sgn);
        sb = to_int(b, sgn);
        sh = int'(b[2:0]);
        r  = 0;
        case (op)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: return a & b;
            3'd3: return ~(a ^ b);
            3'd4: begin
                r = (sa << sh) & ((1 << (2 * W)) - 1);
                if (sgn && r >= (1 << (2 * W - 1))) r = r - (1 << (2 * W));
            end
            3'd5: r = sgn ? (sa >>> sh) : (sa >> sh);
            3'd6: return (sa >= sb) ? W'(1) : W'(0);
            default: r = to_int(acc, sgn) + sb;
        endcase
        if (sat) begin
            lo = sgn ? -(1 << (W - 1)) : 0;
            hi = sgn ? (1 << (W - 1)) - 1 : (1 << W) - 1;
            if (r > hi) r = hi;
            if (r < lo) r = lo;
        end
        return r[W-1:0];
    endfunction

    task automatic model_beat(output logic [AW-1:0] e0, output logic [AW-1:0] e1);
        logic [W-1:0] y0, y1, la, lb;
        logic [2:0]   lop;
        e0 = '0;
        e1 = '0;
        for (int i = 0; i < LANES; i++) begin
            la  = in_a[i*W +: W];
            lb  = in_b[i*W +: W];
            lop = in_op[i*3 +: 3];
            y0  = model_lane(la, lb, lop, in_sgn[i], macc0[i], 1'b0);
            y1  = model_lane(la, lb, lop, in_sgn[i], macc1[i], 1'b1);
            if (lop == 3'd7) begin
                macc0[i] = y0;
                macc1[i] = y1;
            end
            e0[(LANES-1-i)*W +: W] = y0;
            e1[(LANES-1-i)*W +: W] = y1;
        end
    endtask

    function automatic logic [AW-1:0] bp_exp(input int k);
        logic [AW-1:0] e;
        e = '0;
        e[(LANES-1)*W +: W] = W'(k + 2);
        return e;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] e0, e1, ex;
        logic [AW-1:0] q0[$];
        logic [AW-1:0] q1[$];
        int  sent, got, rx0, rx1, cyc;
        bit  took0, took1;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; in_sgn = '0;
        for (int i = 0; i < LANES; i++) begin
            macc0[i] = '0;
            macc1[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {out_valid0, out_valid1}, 2'b00);
        check("reset out_y0", out_y0, '0);
        check("reset out_y1", out_y1, '0);
        check("reset in_ready", {in_ready0, in_ready1}, 2'b11);
        rst_n = 1'b1;
        tick();
        check("post reset out_valid", {out_valid0, out_valid1}, 2'b00);

        add_vec("add_u",      0,  40, 30, OP_ADD,  0,  6, 63);
        add_vec("sub_s",      1, -20, 20, OP_SUB,  1, 24, 32);
        add_vec("shr_s",      3,  -8,  1, OP_SHR,  1, 60, 60);
        add_vec("shr_u",      0,  56,  1, OP_SHR,  0, 28, 28);
        add_vec("sub_u_under",2,   5,  9, OP_SUB,  0, 60,  0);
        add_vec("and",        1,  42, 51, OP_AND,  0, 34, 34);
        add_vec("xnor_s",     3,  42, 51, OP_XNOR, 1, 38, 38);
        add_vec("shl_u_fit",  0,   5,  3, OP_SHL,  0, 40, 40);
        add_vec("shl_u_ovf",  2,  20,  2, OP_SHL,  0, 16, 63);
        add_vec("shl_s_ovf",  1,  -3,  4, OP_SHL,  1, 16, 32);
        add_vec("ge_s_false", 0,  -1,  1, OP_GE,   1,  0,  0);
        add_vec("ge_u_true",  0,  63,  1, OP_GE,   0,  1,  1);
        add_vec("ge_s_eq",    2,   5,  5, OP_GE,   1,  1,  1);
        add_vec("add_s_ovf",  3,  31,  1, OP_ADD,  1, 32, 31);
        add_vec("add_s_neg",  3, -32, -1, OP_ADD,  1, 31, 32);
        add_vec("shl_bidx",   0,   1,  9, OP_SHL,  0,  2,  2);
        add_vec("shr_s_b7",   1, -32,  7, OP_SHR,  1, 63, 63);
        foreach (vecs[i]) begin
            run_single(vecs[i].name, vecs[i].lane, vecs[i].a, vecs[i].b, vecs[i].op,
                       vecs[i].sgn, vecs[i].y_wrap, vecs[i].y_sat);
        end

        // Accumulator on lane 2, then a clear landing with an ACC beat.
        run_single("acc1", 2, 0, 5, OP_ACC, 0, 5, 5);
        run_single("acc2", 2, 0, 5, OP_ACC, 0, 10, 10);
        run_single("acc3", 2, 0, 5, OP_ACC, 0, 15, 15);
        set_lane(2, 0, 7, OP_ACC, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        tick();
        acc_clr  = 1'b0;
        ex = '0;
        ex[(LANES-1-2)*W +: W] = W'(7);
        check("acc_clr y wrap", out_y0, ex);
        check("acc_clr y sat", out_y1, ex);
        $display("vec acc_clr      lane2 b=7 with clear -> wrap=%0d sat=%0d",
                 out_y0[(LANES-1-2)*W +: W], out_y1[(LANES-1-2)*W +: W]);
        run_single("acc_after_clr", 2, 0, 0, OP_ACC, 0, 7, 7);
        run_single("acc_to60", 2, 0, 53, OP_ACC, 0, 60, 60);
        run_single("acc_sat", 2, 0, 10, OP_ACC, 0, 6, 63);

        // Backpressure: two beats in flight, stall, then drain five beats in order.
        out_ready = 1'b1;
        set_lane(0, W'(1), W'(1), OP_ADD, 0);
        in_valid = 1'b1;
        tick();
        set_lane(0, W'(2), W'(1), OP_ADD, 0);
        tick();
        out_ready = 1'b0;
        set_lane(0, W'(3), W'(1), OP_ADD, 0);
        #1;
        for (int c = 0; c < 3; c++) begin
            check("bp stall in_ready", {in_ready0, in_ready1}, 2'b00);
            check("bp stall out_valid", {out_valid0, out_valid1}, 2'b11);
            check("bp stall y0", out_y0, bp_exp(0));
            check("bp stall y1", out_y1, bp_exp(0));
            tick();
        end
        out_ready = 1'b1;
        sent = 2;
        got  = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            #1;
            check("bp drain valid", out_valid0, 1'b1);
            if (out_valid0) begin
                check("bp drain y0", out_y0, bp_exp(got));
                check("bp drain y1", out_y1, bp_exp(got));
                $display("bp beat %0d: y0=%0d", got, out_y0[(LANES-1)*W +: W]);
                got++;
            end
            if (in_valid && in_ready0) sent++;
            tick();
            if (sent < 5) set_lane(0, W'(sent + 1), W'(1), OP_ADD, 0);
            else          in_valid = 1'b0;
        end
        check("bp beat count", got, 5);
        #1;
        check("bp no duplicate", {out_valid0, out_valid1}, 2'b00);

        // Asynchronous reset with both stages occupied.
        tick();
        set_lane(0, W'(9), W'(1), OP_ADD, 0);
        in_valid = 1'b1;
        tick();
        set_lane(0, W'(10), W'(1), OP_ADD, 0);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("rst full out_valid", {out_valid0, out_valid1}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rst async out_valid", {out_valid0, out_valid1}, 2'b00);
        check("rst async y0", out_y0, '0);
        check("rst async y1", out_y1, '0);
        check("rst async in_ready", {in_ready0, in_ready1}, 2'b11);
        $display("async reset mid-stream: out_valid=%0d/%0d", out_valid0, out_valid1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("rst no stale beat", {out_valid0, out_valid1}, 2'b00);
        run_single("acc_post_rst", 2, 0, 3, OP_ACC, 0, 3, 3);

        // Randomised scoreboard run from a fresh reset.
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            macc0[i] = '0;
            macc1[i] = '0;
        end
        in_valid = 1'b0;
        sent = 0; rx0 = 0; rx1 = 0; cyc = 0; took0 = 1'b0;
        while ((rx0 < N_RAND || rx1 < N_RAND) && cyc < 60000) begin
            @(posedge clk);
            #1;
            if (!in_valid || took0) begin
                if (sent < N_RAND) begin
                    in_a     = AW'($urandom);
                    in_b     = AW'($urandom);
                    in_op    = (LANES*3)'($urandom);
                    in_sgn   = LANES'($urandom);
                    in_valid = ($urandom_range(0, 4) != 0);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            took0 = in_valid && in_ready0;
            took1 = in_valid && in_ready1;
            if (took0 || took1) begin
                model_beat(e0, e1);
                if (took0) q0.push_back(e0);
                if (took1) q1.push_back(e1);
                sent++;
            end
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand extra beat wrap: got 0x%0h expected no beat", out_y0);
                end else begin
                    ex = q0.pop_front();
                    check("rand y wrap", out_y0, ex);
                end
                rx0++;
                if (rx0 % 1000 == 0) $display("random: %0d beats received", rx0);
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand extra beat sat: got 0x%0h expected no beat", out_y1);
                end else begin
                    ex = q1.pop_front();
                    check("rand y sat", out_y1, ex);
                end
                rx1++;
            end
            cyc++;
        end
        check("rand beats wrap", rx0, N_RAND);
        check("rand beats sat", rx1, N_RAND);
        check("rand sent", sent, N_RAND);
        check("rand queue wrap empty", q0.size(), 0);
        check("rand queue sat empty", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
